rv32_fetch_stage: RTL and testbench

//  Producer side of the fetch->decode pipeline interface. Generates sequential PCs and issues
//  in-order requests to instruction memory. Buffers returned words and presents one

---
 rtl/rv32_types.sv | 32 +++
 rtl/rv32_fetch_fifo.sv | 86 ++++++++
 rtl/rv32_fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_rv32_fetch_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_types.sv
// ----------------------------------------------------------------------------
// rv32_types
//   Types and constants shared by the fetch stage and its response buffer.
//   rv32_word           : 32-bit architectural word / address
//   fetch_buffer_data_t : {pc, instr} handed from fetch to decode
//   fetch_fifo_entry_t  : {pc, instr} held in the fetch response buffer
//   RV_NOP              : canonical RV32I NOP (addi x0, x0, 0)
//   IMEM_WORD_BYTES     : byte stride between consecutive instruction words
// ----------------------------------------------------------------------------
package rv32_types;

    typedef logic [31:0] rv32_word;

    localparam rv32_word RV_NOP          = 32'h0000_0013;
    localparam int       IMEM_WORD_BYTES = 4;

    typedef struct packed {
        rv32_word pc;
        rv32_word instr;
    } fetch_buffer_data_t;

    typedef struct packed {
        rv32_word pc;
        rv32_word instr;
    } fetch_fifo_entry_t;

    // Address of the next sequential instruction word; wraps mod 2^32.
    function automatic rv32_word next_word_addr(input rv32_word addr);
        return addr + rv32_word'(IMEM_WORD_BYTES);
    endfunction

endpackage

// File: rtl/rv32_fetch_fifo.sv
// ----------------------------------------------------------------------------
// rv32_fetch_fifo
//   Circular buffer of fetch_fifo_entry_t holding instruction words returned
//   by memory until decode consumes them. Push and pop may occur together;
//   flush empties the buffer and wins over push/pop.
//   clk, reset  : clock, asynchronous active-high reset
//   flush       : discard all entries
//   push        : write push_data at the tail
//   pop         : drop the head entry
//   head        : current head entry (valid when !empty)
//   count       : number of stored entries
//   empty, full : occupancy flags
// ----------------------------------------------------------------------------
module rv32_fetch_fifo
    import rv32_types::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  fetch_fifo_entry_t push_data,
    input  logic              pop,
    output fetch_fifo_entry_t head,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_fifo_entry_t mem_q [DEPTH];
    fetch_fifo_entry_t mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rv32_fetch_stage.sv
// ----------------------------------------------------------------------------
// rv32_fetch_stage
//   Producer side of fetch->decode. Issues sequential in-order requests to
//   instruction memory, buffers returned words, and presents one
//   {pc, instr} per cycle to decode, or a NOP bubble when nothing is ready.
//   clk, reset        : clock, asynchronous active-high reset
//   stall             : decode stall, holds the output register
//   redirect          : taken branch/jump; flush and refetch from redirect_pc
//   redirect_pc       : new word-aligned fetch address
//   imem_req_valid    : request valid (out), imem_req_ready: accepted (in)
//   imem_addr         : request address
//   imem_rsp_valid    : in-order response, one word, no backpressure
//   imem_rsp_data     : returned instruction word
//   instr_data        : {pc, instr} to decode
//   set_nop           : 1 = instr_data is a bubble
//   set_nop_pc        : PC tagged on the bubble
// ----------------------------------------------------------------------------
module rv32_fetch_stage
    import rv32_types::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FIFO_DEPTH      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [31:0]        imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [31:0]        imem_rsp_data,
    output fetch_buffer_data_t instr_data,
    output logic               set_nop,
    output logic [31:0]        set_nop_pc
);

    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W  = ((OUT_W > FCNT_W) ? OUT_W : FCNT_W) + 1;

    rv32_word           req_pc_q, req_pc_d;
    rv32_word           rsp_pc_q, rsp_pc_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic [OUT_W-1:0]   drop_q, drop_d;
    fetch_buffer_data_t out_data_q, out_data_d;
    logic               set_nop_q, set_nop_d;
    rv32_word           set_nop_pc_q, set_nop_pc_d;

    logic               fifo_push, fifo_pop, fifo_flush;
    fetch_fifo_entry_t  fifo_push_data, fifo_head;
    logic [FCNT_W-1:0]  fifo_count;
    logic               fifo_empty, fifo_full;
    logic               out_ok, credit_ok, req_fire;

    rv32_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Credit: every in-flight request must already own a buffer slot, so a
    // response can always be absorbed even while decode is stalled.
    assign out_ok         = (outstanding_q < OUT_W'(MAX_OUTSTANDING));
    assign credit_ok      = ((SUM_W'(outstanding_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH));
    assign imem_req_valid = !reset && !redirect && out_ok && credit_ok;
    assign imem_addr      = req_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_data = out_data_q;
    assign set_nop    = set_nop_q;
    assign set_nop_pc = set_nop_pc_q;

    always_comb begin
        req_pc_d       = req_pc_q;
        rsp_pc_d       = rsp_pc_q;
        outstanding_d  = outstanding_q + OUT_W'(req_fire) - OUT_W'(imem_rsp_valid);
        drop_d         = drop_q;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        fifo_flush     = 1'b0;
        fifo_push_data = '{pc: rsp_pc_q, instr: imem_rsp_data};
        out_data_d     = out_data_q;
        set_nop_d      = set_nop_q;
        set_nop_pc_d   = set_nop_pc_q;

        if (req_fire) begin
            req_pc_d = next_word_addr(req_pc_q);
        end

        if (redirect) begin
            req_pc_d     = redirect_pc;
            rsp_pc_d     = redirect_pc;
            fifo_flush   = 1'b1;
            // Everything still in flight belongs to the old path. outstanding
            // already counts words marked for dropping by an earlier redirect,
            // so the new drop total is simply what remains in flight after
            // this cycle's response (if any) is discarded.
            drop_d       = outstanding_q - OUT_W'(imem_rsp_valid);
            out_data_d   = '{pc: redirect_pc, instr: RV_NOP};
            set_nop_d    = 1'b1;
            set_nop_pc_d = redirect_pc;
        end else begin
            if (imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - OUT_W'(1);
                end else begin
                    fifo_push = 1'b1;
                    rsp_pc_d  = next_word_addr(rsp_pc_q);
                end
            end
            // The head is taken from registered FIFO state only, so a word
            // pushed this cycle reaches decode one cycle later.
            if (!stall) begin
                if (!fifo_empty) begin
                    fifo_pop         = 1'b1;
                    out_data_d.pc    = fifo_head.pc;
                    out_data_d.instr = fifo_head.instr;
                    set_nop_d        = 1'b0;
                    set_nop_pc_d     = fifo_head.pc;
                end else begin
                    out_data_d   = '{pc: rsp_pc_q, instr: RV_NOP};
                    set_nop_d    = 1'b1;
                    set_nop_pc_d = rsp_pc_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pc_q      <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            out_data_q    <= '{pc: RESET_PC, instr: RV_NOP};
            set_nop_q     <= 1'b1;
            set_nop_pc_q  <= RESET_PC;
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            out_data_q    <= out_data_d;
            set_nop_q     <= set_nop_d;
            set_nop_pc_q  <= set_nop_pc_d;
        end
    end

    // Credit accounting must make overflow impossible; a push into a full
    // buffer without a matching pop would lose an instruction.
    assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && fifo_full && !fifo_pop));

    assert property (@(posedge clk) disable iff (reset)
        (drop_q <= outstanding_q) && (outstanding_q <= OUT_W'(MAX_OUTSTANDING)));

endmodule

// File: tb/tb_rv32_fetch_stage.sv
module tb_rv32_fetch_stage;
    import rv32_types::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_OUT  = 2;
    localparam int          DEPTH    = 2;

    logic               clk;
    logic               reset;
    logic               stall;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [31:0]        imem_addr;
    logic               imem_rsp_valid;
    logic [31:0]        imem_rsp_data;
    fetch_buffer_data_t instr_data;
    logic               set_nop;
    logic [31:0]        set_nop_pc;

    rv32_fetch_stage #(
        .RESET_PC        (RESET_PC),
        .MAX_OUTSTANDING (MAX_OUT),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_data     (instr_data),
        .set_nop        (set_nop),
        .set_nop_pc     (set_nop_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle's observable behaviour: the request (address only meaningful
    // when valid) and what decode sees (bubble pc or instruction pc).
    typedef struct packed {
        logic        req_valid;
        logic [31:0] req_addr;
        logic        set_nop;
        logic [31:0] out_pc;
        logic [31:0] out_instr;
    } snap_t;

    // An accepted memory request, tagged with the control-flow epoch it
    // belongs to; words from an older epoch are stale.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } memreq_t;

    memreq_t     memq[$];
    logic [31:0] bufq[$];
    logic [31:0] next_req_pc;
    logic [31:0] next_deliver_pc;
    int          epoch;
    logic        hold_nop;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    int          total;
    int          bad;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Drives one clock cycle starting at posedge+1 and advances the reference
    // model: memory returns in order, decode consumes one buffered word per
    // unstalled cycle, and a redirect kills every word from before it.
    task automatic drive_cycle(input logic st, input logic rd, input logic [31:0] rp,
                               input logic rdy, input logic rsp_en,
                               output snap_t e, output snap_t o);
        logic    exp_valid;
        logic    rsp;
        memreq_t head;
        memreq_t nreq;
        e = '0;
        o = '0;
        stall          = st;
        redirect       = rd;
        redirect_pc    = rp;
        imem_req_ready = rdy;
        rsp            = rsp_en && (memq.size() > 0);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(memq[0].addr) : 32'hDEAD_BEEF;
        exp_valid      = !rd && (memq.size() < MAX_OUT) && ((memq.size() + bufq.size()) < DEPTH);
        e.req_valid    = exp_valid;
        e.req_addr     = exp_valid ? next_req_pc : 32'h0;
        #1;
        o.req_valid = imem_req_valid;
        o.req_addr  = imem_req_valid ? imem_addr : 32'h0;
        if (rd) begin
            hold_nop        = 1'b1;
            hold_pc         = rp;
            hold_instr      = RV_NOP;
            next_deliver_pc = rp;
        end else if (!st) begin
            if (bufq.size() > 0) begin
                hold_nop        = 1'b0;
                hold_pc         = bufq.pop_front();
                hold_instr      = mem_word(hold_pc);
                next_deliver_pc = hold_pc + 32'd4;
            end else begin
                hold_nop   = 1'b1;
                hold_pc    = next_deliver_pc;
                hold_instr = RV_NOP;
            end
        end
        if (rsp) begin
            head = memq.pop_front();
            if (!rd && head.epoch == epoch) bufq.push_back(head.addr);
        end
        if (rd) begin
            bufq.delete();
            epoch++;
            next_req_pc = rp;
        end
        if (exp_valid && rdy) begin
            nreq.addr  = next_req_pc;
            nreq.epoch = epoch;
            memq.push_back(nreq);
            next_req_pc = next_req_pc + 32'd4;
        end
        e.set_nop   = hold_nop;
        e.out_pc    = hold_pc;
        e.out_instr = hold_instr;
        @(posedge clk);
        #1;
        o.set_nop   = set_nop;
        o.out_pc    = set_nop ? set_nop_pc : instr_data.pc;
        o.out_instr = instr_data.instr;
    endtask

    // Asserts reset mid-cycle (no clock edge involved), samples outputs right
    // away, holds reset across one edge and releases it at posedge+1.
    task automatic apply_reset(output snap_t o, output logic [31:0] dpc);
        #3;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        o.req_valid = imem_req_valid;
        o.req_addr  = imem_req_valid ? imem_addr : 32'h0;
        o.set_nop   = set_nop;
        o.out_pc    = set_nop ? set_nop_pc : instr_data.pc;
        o.out_instr = instr_data.instr;
        dpc         = instr_data.pc;
        memq.delete();
        bufq.delete();
        epoch++;
        next_req_pc     = RESET_PC;
        next_deliver_pc = RESET_PC;
        hold_nop        = 1'b1;
        hold_pc         = RESET_PC;
        hold_instr      = RV_NOP;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        snap_t       e, o, rexp;
        logic [31:0] dpc;
        rexp = '{req_valid: 1'b0, req_addr: 32'h0, set_nop: 1'b1, out_pc: RESET_PC, out_instr: RV_NOP};
        apply_reset(o, dpc);
        total++;
        if (o !== rexp) begin bad++; $display("[TB] FAIL reset_state got=%h exp=%h", o, rexp); end
        total++;
        if (dpc !== RESET_PC) begin bad++; $display("[TB] FAIL reset_instr_pc got=%h exp=%h", dpc, RESET_PC); end
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, e, o);
        total++;
        if (o !== e) begin bad++; $display("[TB] FAIL first_req got=%h exp=%h", o, e); end
    endtask

    task automatic test_stream();
        snap_t e, o;
        logic  seen;
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, e, o);
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL stream cyc=%0d got=%h exp=%h", i, o, e); end
            if (!o.set_nop && !seen) begin
                seen = 1'b1;
                total++;
                if (o.out_pc !== RESET_PC) begin bad++; $display("[TB] FAIL first_instr_pc got=%h exp=%h", o.out_pc, RESET_PC); end
            end
        end
    endtask

    task automatic test_stall();
        snap_t e, o;
        for (int i = 0; i < 16; i++) begin
            drive_cycle((i >= 3 && i < 8), 1'b0, 32'h0, 1'b1, 1'b1, e, o);
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL stall cyc=%0d got=%h exp=%h", i, o, e); end
        end
    endtask

    task automatic test_redirect();
        snap_t e, o;
        for (int i = 0; i < 6 && memq.size() < MAX_OUT; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, e, o);
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL redir_fill cyc=%0d got=%h exp=%h", i, o, e); end
        end
        drive_cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1, e, o);
        total++;
        if (o !== e) begin bad++; $display("[TB] FAIL redir_bubble got=%h exp=%h", o, e); end
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, e, o);
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL redir_after cyc=%0d got=%h exp=%h", i, o, e); end
        end
    endtask

    task automatic test_ready_low();
        snap_t e, o;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, (i >= 3), 1'b1, e, o);
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL ready_low cyc=%0d got=%h exp=%h", i, o, e); end
        end
    endtask

    task automatic test_redirect_stall();
        snap_t e, o;
        for (int i = 0; i < 10; i++) begin
            drive_cycle((i < 3), (i == 2), 32'h0000_2000, 1'b1, 1'b1, e, o);
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL redir_stall cyc=%0d got=%h exp=%h", i, o, e); end
        end
    endtask

    task automatic test_wrap();
        snap_t e, o;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1'b0, (i == 0), 32'hFFFF_FFF8, 1'b1, 1'b1, e, o);
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL wrap cyc=%0d got=%h exp=%h", i, o, e); end
        end
    endtask

    task automatic test_reset_mid_burst();
        snap_t       e, o, rexp;
        logic [31:0] dpc;
        rexp = '{req_valid: 1'b0, req_addr: 32'h0, set_nop: 1'b1, out_pc: RESET_PC, out_instr: RV_NOP};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, e, o);
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL burst cyc=%0d got=%h exp=%h", i, o, e); end
        end
        apply_reset(o, dpc);
        total++;
        if (o !== rexp) begin bad++; $display("[TB] FAIL midreset_state got=%h exp=%h", o, rexp); end
        total++;
        if (dpc !== RESET_PC) begin bad++; $display("[TB] FAIL midreset_instr_pc got=%h exp=%h", dpc, RESET_PC); end
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, e, o);
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL after_reset cyc=%0d got=%h exp=%h", i, o, e); end
        end
    endtask

    task automatic test_random();
        snap_t       e, o;
        logic [31:0] r;
        for (int i = 0; i < 500; i++) begin
            r = $urandom();
            drive_cycle(($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 7),
                        {r[31:2], 2'b00}, ($urandom_range(0, 99) < 70),
                        ($urandom_range(0, 99) < 60), e, o);
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL random cyc=%0d got=%h exp=%h", i, o, e); end
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        epoch          = 0;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        next_req_pc     = RESET_PC;
        next_deliver_pc = RESET_PC;
        hold_nop        = 1'b1;
        hold_pc         = RESET_PC;
        hold_instr      = RV_NOP;
        @(posedge clk);
        #1;
        $display("[TB] starting fetch stage tests");
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_ready_low();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
